// File: rtl/word_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | word_selector                                                              |
// | Grabs a random index, rejects immediate repeats, then reads a five-letter  |
// | word from a synchronous ROM one letter per cycle and presents it valid.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module word_selector #(
    parameter int WORD_COUNT = 100,
    parameter int LETTERS    = 5,
    parameter int LETTER_W   = 5,
    parameter int MAX_RETRY  = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         new_word,
    input  logic [6:0]                   rand_num,
    input  logic [LETTER_W-1:0]          rom_data,
    output logic                         grab_word,
    output logic [8:0]                   rom_addr,
    output logic [LETTERS*LETTER_W-1:0]  word,
    output logic [6:0]                   word_index,
    output logic                         word_valid,
    output logic                         busy,
    output logic                         range_err
);

    localparam int c_k_w     = (LETTERS > 1) ? $clog2(LETTERS) : 1;
    localparam int c_retry_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [6:0]           c_word_count = 7'(WORD_COUNT);
    localparam logic [8:0]           c_letters9   = 9'(LETTERS);
    localparam logic [c_k_w-1:0]     c_last_k     = c_k_w'(LETTERS - 1);
    localparam logic [c_retry_w-1:0] c_max_retry  = c_retry_w'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRAB   = 3'd1,
        S_SETTLE = 3'd2,
        S_LATCH  = 3'd3,
        S_FETCH  = 3'd4,
        S_LAST   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [6:0]                    r_idx;
    logic [6:0]                    r_last_idx;
    logic [c_retry_w-1:0]          r_retry;
    logic [c_k_w-1:0]              r_k;
    logic                          r_grab;
    logic [8:0]                    r_rom_addr;
    logic [LETTERS*LETTER_W-1:0]   r_word;
    logic [6:0]                    r_word_index;
    logic                          r_range_err;

    logic                          w_bad;
    logic [6:0]                    w_idx;
    logic                          w_retry;
    logic [8:0]                    w_base;

    // Out-of-range generator values collapse to index 1 before the repeat check.
    assign w_bad   = (rand_num == 7'd0) || (rand_num > c_word_count);
    assign w_idx   = w_bad ? 7'd1 : rand_num;
    assign w_retry = (w_idx == r_last_idx) && (r_retry < c_max_retry);
    assign w_base  = ({2'b00, w_idx} - 9'd1) * c_letters9;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (new_word) w_next = S_GRAB;
            S_GRAB:         w_next = S_SETTLE;
            S_SETTLE:       w_next = S_LATCH;
            S_LATCH:        w_next = w_retry ? S_GRAB : S_FETCH;
            S_FETCH:        if (r_k == c_last_k) w_next = S_LAST;
            S_LAST:         w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_last_idx   <= '0;
            r_retry      <= '0;
            r_k          <= '0;
            r_grab       <= 1'b0;
            r_rom_addr   <= '0;
            r_word       <= '0;
            r_word_index <= '0;
            r_range_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_grab  <= (w_next == S_GRAB);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (new_word) begin
                        r_retry     <= '0;
                        r_range_err <= 1'b0;
                    end
                end
                S_LATCH: begin
                    r_idx <= w_idx;
                    if (w_bad) r_range_err <= 1'b1;
                    if (w_retry) begin
                        r_retry <= r_retry + 1'b1;
                    end else begin
                        r_k        <= '0;
                        r_rom_addr <= w_base;
                    end
                end
                S_FETCH: begin
                    // Data arriving now belongs to the address issued last cycle.
                    if (r_k != '0) begin
                        r_word[(LETTERS - int'(r_k)) * LETTER_W +: LETTER_W] <= rom_data;
                    end
                    if (r_k != c_last_k) begin
                        r_k        <= r_k + 1'b1;
                        r_rom_addr <= r_rom_addr + 9'd1;
                    end
                end
                S_LAST: begin
                    r_word[LETTER_W-1:0] <= rom_data;
                    r_last_idx           <= r_idx;
                    r_word_index         <= r_idx;
                end
                default: ;
            endcase
        end
    end

    assign grab_word  = r_grab;
    assign rom_addr   = r_rom_addr;
    assign word       = r_word;
    assign word_index = r_word_index;
    assign word_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign range_err  = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_word_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_word_selector                                                           |
// | Scoreboard bench: generator + ROM models, queued expectations, monitor.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_word_selector;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b1;
    logic        new_word = 1'b0;
    logic [6:0]  rand_num = 7'd0;
    logic [4:0]  rom_data = 5'd0;
    logic        grab_word;
    logic [8:0]  rom_addr;
    logic [24:0] word;
    logic [6:0]  word_index;
    logic        word_valid;
    logic        busy;
    logic        range_err;

    word_selector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .new_word   (new_word),
        .rand_num   (rand_num),
        .rom_data   (rom_data),
        .grab_word  (grab_word),
        .rom_addr   (rom_addr),
        .word       (word),
        .word_index (word_index),
        .word_valid (word_valid),
        .busy       (busy),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM: word 37 is CRANE, everything else a fixed pattern.
    function automatic logic [4:0] letter_at(int a);
        if (a == 180) return 5'd3;
        if (a == 181) return 5'd18;
        if (a == 182) return 5'd1;
        if (a == 183) return 5'd14;
        if (a == 184) return 5'd5;
        return 5'(((a * 7) + 3) % 26 + 1);
    endfunction

    function automatic logic [24:0] exp_word(int idx);
        logic [24:0] w;
        w = '0;
        for (int j = 0; j < 5; j++) w = {w[19:0], letter_at((idx - 1) * 5 + j)};
        return w;
    endfunction

    logic [4:0] rom_mem [0:511];
    initial for (int a = 0; a < 512; a++) rom_mem[a] = letter_at(a);
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Generator: each grab pulse advances to the next queued value.
    logic [6:0] gen_mem [0:63];
    int gen_wr = 0;
    int gen_rd = 0;
    always @(posedge clk) begin
        if (grab_word && gen_rd != gen_wr) begin
            rand_num <= gen_mem[gen_rd];
            gen_rd   <= gen_rd + 1;
        end
    end

    typedef struct {
        logic [24:0] word;
        logic [6:0]  idx;
        logic        rerr;
        int          lat;
        int          grabs;
        logic [8:0]  base;
        int          t0;
        int          g0;
    } exp_t;

    exp_t sb [$];
    int checks     = 0;
    int errors     = 0;
    int issued     = 0;
    int done_cnt   = 0;
    int grab_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grab"},  64'(grab_word),  64'd0);
        check({tag, "_valid"}, 64'(word_valid), 64'd0);
        check({tag, "_busy"},  64'(busy),       64'd0);
        check({tag, "_rerr"},  64'(range_err),  64'd0);
        check({tag, "_word"},  64'(word),       64'd0);
        check({tag, "_index"}, 64'(word_index), 64'd0);
        check({tag, "_addr"},  64'(rom_addr),   64'd0);
    endtask

    task automatic push_gen(input logic [6:0] v);
        gen_mem[gen_wr] = v;
        gen_wr++;
    endtask

    // Returns just after the edge that samples new_word (DUT now in GRAB).
    task automatic request(input logic [6:0] idx, input logic [24:0] w, input logic rerr,
                           input int lat, input int grabs, input bit expect_it);
        exp_t e;
        @(negedge clk);
        new_word = 1'b1;
        @(posedge clk);
        #1;
        new_word = 1'b0;
        e.word  = w;
        e.idx   = idx;
        e.rerr  = rerr;
        e.lat   = lat;
        e.grabs = grabs;
        e.base  = 9'((idx - 1) * 5);
        e.t0    = cyc;
        e.g0    = grab_total;
        if (expect_it) begin
            sb.push_back(e);
            issued++;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_cnt < issued; i++) @(negedge clk);
        if (done_cnt < issued) begin
            checks++;
            errors++;
            $display("FAIL completion_timeout actual=%0d required=%0d", done_cnt, issued);
            issued = done_cnt;
        end
        @(negedge clk);
    endtask

    // Monitor: samples on the falling edge, scores each rising word_valid.
    logic [8:0] hist [0:6];
    logic       prev_valid = 1'b0;
    initial begin
        exp_t e;
        for (int i = 0; i < 7; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = rom_addr;
            if (grab_word) grab_total++;
            if (word_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("word",       64'(word),       64'(e.word));
                    check("word_index", 64'(word_index), 64'(e.idx));
                    check("range_err",  64'(range_err),  64'(e.rerr));
                    check("latency",    64'(cyc - e.t0 + 1), 64'(e.lat));
                    check("grab_count", 64'(grab_total - e.g0), 64'(e.grabs));
                    check("addr_seq", 64'({hist[6], hist[5], hist[4], hist[3], hist[2]}),
                          64'({e.base, e.base + 9'd1, e.base + 9'd2, e.base + 9'd3, e.base + 9'd4}));
                end
                done_cnt++;
            end
            prev_valid = word_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset_n = 1'b0;
        #1 check_zero("por");
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        push_gen(7'd37);
        request(7'd37, {5'd3, 5'd18, 5'd1, 5'd14, 5'd5}, 1'b0, 10, 1, 1'b1);
        wait_done();

        repeat (4) push_gen(7'd37);
        request(7'd37, {5'd3, 5'd18, 5'd1, 5'd14, 5'd5}, 1'b0, 19, 4, 1'b1);
        wait_done();

        push_gen(7'd37);
        push_gen(7'd52);
        request(7'd52, exp_word(52), 1'b0, 13, 2, 1'b1);
        wait_done();

        push_gen(7'd0);
        request(7'd1, exp_word(1), 1'b1, 10, 1, 1'b1);
        wait_done();

        push_gen(7'd100);
        request(7'd100, exp_word(100), 1'b0, 10, 1, 1'b1);
        check("rerr_clear_a", 64'(range_err), 64'd0);
        wait_done();

        push_gen(7'd127);
        request(7'd1, exp_word(1), 1'b1, 10, 1, 1'b1);
        wait_done();

        // Abort during FETCH k=2 of index 60; no valid may follow.
        push_gen(7'd60);
        request(7'd60, exp_word(60), 1'b0, 10, 1, 1'b0);
        check("rerr_clear_b", 64'(range_err), 64'd0);
        repeat (5) @(posedge clk);
        #2;
        check("abort_busy", 64'(busy), 64'd1);
        check("abort_addr", 64'(rom_addr), 64'd297);
        reset_n = 1'b0;
        #1 check_zero("abort");
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Index 1 matches the last completed word, but reset cleared the history.
        push_gen(7'd1);
        request(7'd1, exp_word(1), 1'b0, 10, 1, 1'b1);
        repeat (3) begin
            @(negedge clk) new_word = 1'b1;
            @(negedge clk) new_word = 1'b0;
        end
        wait_done();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/word_selector.md
# word_selector

Downstream consumer of the random number generator. On a new-word request it pulses `grab_word` to advance the generator, waits for `rand_num` (1..100) to settle, and rejects immediate repeats of the previous index. It then reads the chosen five-letter word from the synchronous word ROM one letter per cycle and presents the assembled word, with a valid flag, to the game logic.

## Interface
- `WORD_COUNT`, 100, number of words in the ROM; legal indices are 1..WORD_COUNT.
- `LETTERS`, 5, letters per word.
- `LETTER_W`, 5, bits per letter code (A=1 .. Z=26).
- `MAX_RETRY`, 3, re-grabs allowed when the new index equals the previous one.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `new_word`  in  1  request a new word; sampled only in IDLE and DONE.
- `rand_num`  in  7  current generator output, expected range 1..100.
- `rom_data`  in  LETTER_W  ROM read data, valid one cycle after `rom_addr`.
- `grab_word`  out  1  one-cycle registered pulse that advances the generator.
- `rom_addr`  out  9  ROM letter address = (index-1)*LETTERS + k.
- `word`  out  LETTERS*LETTER_W  assembled word; letter 0 in the MSBs.
- `word_index`  out  7  accepted index, 1..100.
- `word_valid`  out  1  high while in DONE.
- `busy`  out  1  high in every state except IDLE and DONE.
- `range_err`  out  1  sticky flag for an out-of-range `rand_num`; cleared on the next accepted `new_word`.

## Operation
- States: IDLE, GRAB, SETTLE, LATCH, FETCH, LAST, DONE.
- IDLE / DONE:
  - `new_word`=1 → GRAB.
  - Retry counter clears.
  - `range_err` clears.
- GRAB: `grab_word`=1 for exactly this cycle. The signal is a register output with no glitches. Next state is SETTLE.
- SETTLE: one cycle so the generator's combinational output can settle. Next state is LATCH.
- LATCH: sample `rand_num` into idx.
  - If idx==0 or idx>WORD_COUNT: force idx=1 and set `range_err`.
  - If idx equals `last_idx` and retry<MAX_RETRY: increment retry and go to GRAB.
  - Otherwise: go to FETCH with k=0.
  - `last_idx` resets to 0, so the first request never retries.
- FETCH: drive `rom_addr`=(idx-1)*LETTERS+k.
  - k runs 0..LETTERS-1, one per cycle.
  - `rom_data` returned in cycle t+1 is written to letter slot k-1.
  - After k=LETTERS-1, go to LAST.
- LAST: capture the final letter. Update `last_idx`=idx and `word_index`=idx. Go to DONE.
- DONE: `word_valid`=1; `word` and `word_index` are held stable.
- During a fetch, `word` keeps its previous contents until each slot is overwritten. Consumers use it only while `word_valid`=1.
- Width rule: the address is computed in 9 bits; the maximum is 99*5+4=499, so there is no overflow.
- `new_word` asserted while `busy` is ignored. It is not queued.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - State goes to IDLE.
  - `grab_word`, `word_valid`, `busy`, and `range_err` are 0.
  - `word`, `word_index`, `rom_addr`, `last_idx`, and retry are 0.
- Reset mid-fetch aborts immediately. No partial word is ever flagged valid.
- Latency without retry: `new_word` sampled at edge 0.
  - GRAB is cycle 1.
  - SETTLE is cycle 2.
  - LATCH is cycle 3.
  - FETCH is cycles 4–8.
  - LAST is cycle 9.
  - `word_valid` rises at cycle 10.
- Each retry adds 3 cycles (GRAB, SETTLE, LATCH).
- Worst case is 10+3·MAX_RETRY = 19 cycles.
- `busy` rises in the cycle after `new_word` is sampled and falls when DONE is entered.
- `word_valid` falls in the cycle after `new_word` is sampled in DONE.
- `rom_addr` holds its last value outside FETCH.

## Test plan
- Reset, then `new_word` pulse with `rand_num`=37 and ROM word 37 = "CRANE" (3,18,1,14,5):
  - `grab_word` pulses once at cycle 1.
  - `rom_addr` goes 180..184.
  - `word`={3,18,1,14,5} and `word_index`=37 at cycle 10.
- Second request with `rand_num` stuck at 37:
  - Exactly 3 extra `grab_word` pulses.
  - Accepted index 37 at cycle 19.
- `rand_num` changes 37→37→52 on successive grabs: one retry, `word_index`=52, `rom_addr` starts at 255, valid at cycle 13.
- `rand_num`=0, then separately `rand_num`=127:
  - `range_err`=1 in each case.
  - `word_index`=1 and `rom_addr` goes 0..4.
  - `range_err` clears on the next `new_word`.
- `rand_num`=100: `rom_addr` reaches 499 and `word_index`=100.
- Assert `reset_n`=0 during FETCH at k=2:
  - All outputs are 0 immediately.
  - After release, a new request completes normally with `word_index` not treated as a repeat.
  - `new_word` pulses during busy cycles produce no extra `grab_word`.
